// File: rtl/accum_result_monitor_pkg.sv
// accum_result_monitor_pkg: monitor FSM state encoding and saturating-increment helper.
`default_nettype none
package accum_result_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } mon_state_e;

  // Counters are carried in 64 bits so one helper serves every CNT_W; callers truncate.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accum_result_monitor_if.sv
// accum_result_monitor_if: control and observation bus between the accumulator side and the monitor.
`default_nettype none
interface accum_result_monitor_if #(
  parameter int W = 32
) ();
  logic         enable;
  logic         clear;
  logic [W-1:0] accum_in;
  logic         accum_bypass;
  logic [W-1:0] accum_out;
  logic [W-1:0] accum_bypass_out;

  modport master (
    output enable, clear, accum_in, accum_bypass, accum_out, accum_bypass_out
  );

  modport slave (
    input enable, clear, accum_in, accum_bypass, accum_out, accum_bypass_out
  );
endinterface
`default_nettype wire

// File: rtl/accum_result_monitor_ref_model.sv
// accum_ref_model: expected accumulator value (exp += in + SECRET_VALUE, mod 2^W) and bypass expectation.
`default_nettype none
module accum_ref_model
  import accum_result_monitor_pkg::*;
#(
  parameter int W            = 32,
  parameter int SECRET_VALUE = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         update_i,
  input  logic [W-1:0] accum_in_i,
  input  logic         accum_bypass_i,
  output logic [W-1:0] exp_o,
  output logic [W-1:0] byp_exp_o
);

  logic [W-1:0] exp_q, exp_d;

  always_comb begin
    exp_d = exp_q;
    if (clear_i) begin
      exp_d = '0;
    end else if (update_i) begin
      exp_d = exp_q + accum_in_i + W'(SECRET_VALUE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_o     = exp_q;
  assign byp_exp_o = accum_bypass_i ? accum_in_i : exp_q;

endmodule
`default_nettype wire

// File: rtl/accum_result_monitor.sv
// accum_result_monitor: checks the upstream accumulator against a reference model with sticky error,
// saturating counters and first-failure capture. Optional ACCUM_RESULT_MONITOR_BYPASS_CHECK_EN adds the bypass compare.
`default_nettype none
module accum_result_monitor
  import accum_result_monitor_pkg::*;
#(
  parameter int W            = 32,
  parameter int SECRET_VALUE = 7,
  parameter int WARMUP       = 1,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_ERR  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  accum_result_monitor_if.slave mon_if,
  output logic                  err_o,
  output logic [CNT_W-1:0]      err_count_o,
  output logic [CNT_W-1:0]      checked_count_o,
  output logic [CNT_W-1:0]      first_err_cyc_o,
  output logic [W-1:0]          first_err_exp_o,
  output logic [W-1:0]          first_err_got_o,
  output mon_state_e            mon_state_o
);

  mon_state_e       state_q, state_d;
  logic [3:0]       warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, err_cnt_q, err_cnt_d, chk_q, chk_d, ferr_cyc_q, ferr_cyc_d;
  logic [W-1:0]     ferr_exp_q, ferr_exp_d, ferr_got_q, ferr_got_d;
  logic             err_q, err_d;

  logic             live;
  logic             compare_act;
  logic             model_upd;
  logic             byp_bad;
  logic             mismatch;
  logic [W-1:0]     exp_val;
  logic [W-1:0]     byp_exp;

  accum_ref_model #(
    .W            (W),
    .SECRET_VALUE (SECRET_VALUE)
  ) u_ref_model (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (mon_if.clear),
    .update_i       (model_upd),
    .accum_in_i     (mon_if.accum_in),
    .accum_bypass_i (mon_if.accum_bypass),
    .exp_o          (exp_val),
    .byp_exp_o      (byp_exp)
  );

`ifdef ACCUM_RESULT_MONITOR_BYPASS_CHECK_EN
  assign byp_bad = (mon_if.accum_bypass_out != byp_exp);
`else
  assign byp_bad = 1'b0;
  logic unused_bypass;
  assign unused_bypass = ^{mon_if.accum_bypass_out, byp_exp};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // The IDLE->WARM edge is the first warm-up cycle, so the WARM edge seen with
  // warm_cnt==0 is already a compared cycle.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (mon_if.clear) begin
      state_d    = IDLE;
      warm_cnt_d = '0;
    end else if (mon_if.enable) begin
      case (state_q)
        IDLE: begin
          state_d    = WARM;
          warm_cnt_d = 4'(WARMUP - 1);
        end
        WARM: begin
          if (warm_cnt_q == 4'd0) begin
            state_d = (mismatch && (STOP_ON_ERR != 0)) ? FAIL : CHECK;
          end else begin
            warm_cnt_d = warm_cnt_q - 4'd1;
          end
        end
        CHECK: begin
          if (mismatch && (STOP_ON_ERR != 0)) begin
            state_d = FAIL;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    live        = mon_if.enable && !mon_if.clear;
    model_upd   = live && (state_q != FAIL);
    compare_act = live && ((state_q == CHECK) ||
                           ((state_q == WARM) && (warm_cnt_q == 4'd0)));
    mismatch    = compare_act && ((mon_if.accum_out != exp_val) || byp_bad);
    mon_state_o = state_q;
  end

  always_comb begin
    cyc_d      = cyc_q;
    err_cnt_d  = err_cnt_q;
    chk_d      = chk_q;
    err_d      = err_q;
    ferr_cyc_d = ferr_cyc_q;
    ferr_exp_d = ferr_exp_q;
    ferr_got_d = ferr_got_q;
    if (mon_if.clear) begin
      cyc_d      = '0;
      err_cnt_d  = '0;
      chk_d      = '0;
      err_d      = 1'b0;
      ferr_cyc_d = '0;
      ferr_exp_d = '0;
      ferr_got_d = '0;
    end else if (model_upd) begin
      cyc_d = CNT_W'(sat_inc(64'(cyc_q), CNT_W));
      if (compare_act) begin
        chk_d = CNT_W'(sat_inc(64'(chk_q), CNT_W));
      end
      if (mismatch) begin
        err_d     = 1'b1;
        err_cnt_d = CNT_W'(sat_inc(64'(err_cnt_q), CNT_W));
        if (!err_q) begin
          ferr_cyc_d = cyc_q;
          ferr_exp_d = exp_val;
          ferr_got_d = mon_if.accum_out;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q      <= '0;
      err_cnt_q  <= '0;
      chk_q      <= '0;
      err_q      <= 1'b0;
      ferr_cyc_q <= '0;
      ferr_exp_q <= '0;
      ferr_got_q <= '0;
    end else begin
      cyc_q      <= cyc_d;
      err_cnt_q  <= err_cnt_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      ferr_cyc_q <= ferr_cyc_d;
      ferr_exp_q <= ferr_exp_d;
      ferr_got_q <= ferr_got_d;
    end
  end

  assign err_o           = err_q;
  assign err_count_o     = err_cnt_q;
  assign checked_count_o = chk_q;
  assign first_err_cyc_o = ferr_cyc_q;
  assign first_err_exp_o = ferr_exp_q;
  assign first_err_got_o = ferr_got_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_result_monitor.sv
// tb_accum_result_monitor: directed checks of the result monitor in three parameter sets sharing one bus.
`default_nettype none
module tb_accum_result_monitor;
  import accum_result_monitor_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  accum_result_monitor_if #(.W(32)) bus ();

  logic        err_a, err_n, err_c;
  logic [15:0] ecnt_a, chk_a, fcyc_a, ecnt_n, chk_n, fcyc_n;
  logic [3:0]  ecnt_c, chk_c, fcyc_c;
  logic [31:0] fexp_a, fgot_a, fexp_n, fgot_n, fexp_c, fgot_c;
  mon_state_e  st_a, st_n, st_c;

  accum_result_monitor #(.W(32), .SECRET_VALUE(7), .WARMUP(1), .CNT_W(16), .STOP_ON_ERR(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .mon_if(bus),
    .err_o(err_a), .err_count_o(ecnt_a), .checked_count_o(chk_a), .first_err_cyc_o(fcyc_a),
    .first_err_exp_o(fexp_a), .first_err_got_o(fgot_a), .mon_state_o(st_a));

  accum_result_monitor #(.W(32), .SECRET_VALUE(7), .WARMUP(1), .CNT_W(16), .STOP_ON_ERR(0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .mon_if(bus),
    .err_o(err_n), .err_count_o(ecnt_n), .checked_count_o(chk_n), .first_err_cyc_o(fcyc_n),
    .first_err_exp_o(fexp_n), .first_err_got_o(fgot_n), .mon_state_o(st_n));

  accum_result_monitor #(.W(32), .SECRET_VALUE(7), .WARMUP(1), .CNT_W(4), .STOP_ON_ERR(0)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .mon_if(bus),
    .err_o(err_c), .err_count_o(ecnt_c), .checked_count_o(chk_c), .first_err_cyc_o(fcyc_c),
    .first_err_exp_o(fexp_c), .first_err_got_o(fgot_c), .mon_state_o(st_c));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc;          // behaviour of the upstream accumulator
  logic        byp_sel;
  logic        byp_use_exp;

  // One clock of stimulus; flip corrupts accum_out. Outputs are sampled 1ns after the edge.
  task automatic cyc(input logic en, input logic [31:0] din, input logic [31:0] flip, input logic clr);
    bus.enable           = en;
    bus.clear            = clr;
    bus.accum_in         = din;
    bus.accum_bypass     = byp_sel;
    bus.accum_out        = acc ^ flip;
    bus.accum_bypass_out = (byp_sel && !byp_use_exp) ? din : acc;
    @(posedge clk);
    #1;
    if (clr) acc = 32'd0;
    else if (en) acc = acc + din + 32'd7;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
  endtask

  task automatic do_clear();
    byp_sel = 1'b0; byp_use_exp = 1'b0;
    cyc(1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    checks++; if (err_a !== 1'b0)   begin errors++; $display("FAIL reset_err got %0d want 0", err_a); end
    checks++; if (ecnt_a !== 16'd0) begin errors++; $display("FAIL reset_ecnt got %0d want 0", ecnt_a); end
    checks++; if (chk_a !== 16'd0)  begin errors++; $display("FAIL reset_chk got %0d want 0", chk_a); end
    checks++; if ({fcyc_a, fexp_a, fgot_a} !== 64'd0) begin errors++; $display("FAIL reset_capture got %h/%h/%h want 0", fcyc_a, fexp_a, fgot_a); end
    checks++; if (st_a !== IDLE)    begin errors++; $display("FAIL reset_state got %0d want 0", st_a); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_run();
    do_clear();
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 32'(5 * k), 32'd0, 1'b0);
      if (k == 0) begin
        checks++; if (st_a !== WARM) begin errors++; $display("FAIL warm_state got %0d want 1", st_a); end
      end
      if (k == 1) begin
        checks++; if (chk_a !== 16'd1) begin errors++; $display("FAIL first_check got %0d want 1", chk_a); end
      end
    end
    checks++; if (err_a !== 1'b0)    begin errors++; $display("FAIL clean_err got %0d want 0", err_a); end
    checks++; if (ecnt_a !== 16'd0)  begin errors++; $display("FAIL clean_ecnt got %0d want 0", ecnt_a); end
    checks++; if (chk_a !== 16'd19)  begin errors++; $display("FAIL clean_chk got %0d want 19", chk_a); end
    checks++; if (st_a !== CHECK)    begin errors++; $display("FAIL clean_state got %0d want 2", st_a); end
  endtask

  task automatic test_stop_on_err();
    do_clear();
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 32'(5 * k), (k == 6) ? 32'd1 : 32'd0, 1'b0);
      if (k == 6) begin
        checks++; if (err_a !== 1'b1)        begin errors++; $display("FAIL stop_err got %0d want 1", err_a); end
        checks++; if (fcyc_a !== 16'd6)      begin errors++; $display("FAIL stop_fcyc got %0d want 6", fcyc_a); end
        checks++; if (fexp_a !== 32'h75)     begin errors++; $display("FAIL stop_fexp got %h want 75", fexp_a); end
        checks++; if (fgot_a !== 32'h74)     begin errors++; $display("FAIL stop_fgot got %h want 74", fgot_a); end
        checks++; if (st_a !== FAIL)         begin errors++; $display("FAIL stop_state got %0d want 3", st_a); end
      end
    end
    checks++; if (chk_a !== 16'd6)  begin errors++; $display("FAIL frozen_chk got %0d want 6", chk_a); end
    checks++; if (ecnt_a !== 16'd1) begin errors++; $display("FAIL frozen_ecnt got %0d want 1", ecnt_a); end
    checks++; if (st_a !== FAIL)    begin errors++; $display("FAIL frozen_state got %0d want 3", st_a); end
  endtask

  task automatic test_continue();
    do_clear();
    for (int k = 0; k < 15; k++)
      cyc(1'b1, 32'(5 * k), (k == 4 || k == 9 || k == 12) ? 32'd1 : 32'd0, 1'b0);
    checks++; if (ecnt_n !== 16'd3)  begin errors++; $display("FAIL cont_ecnt got %0d want 3", ecnt_n); end
    checks++; if (fcyc_n !== 16'd4)  begin errors++; $display("FAIL cont_fcyc got %0d want 4", fcyc_n); end
    checks++; if (fexp_n !== 32'h3A) begin errors++; $display("FAIL cont_fexp got %h want 3a", fexp_n); end
    checks++; if (fgot_n !== 32'h3B) begin errors++; $display("FAIL cont_fgot got %h want 3b", fgot_n); end
    checks++; if (chk_n !== 16'd14)  begin errors++; $display("FAIL cont_chk got %0d want 14", chk_n); end
    checks++; if (st_n !== CHECK)    begin errors++; $display("FAIL cont_state got %0d want 2", st_n); end
  endtask

  task automatic test_enable_hold();
    do_clear();
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'(5 * k), 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd123, 32'd1, 1'b0);
    checks++; if (err_a !== 1'b0)   begin errors++; $display("FAIL hold_err got %0d want 0", err_a); end
    checks++; if (chk_a !== 16'd4)  begin errors++; $display("FAIL hold_chk got %0d want 4", chk_a); end
    checks++; if (st_a !== CHECK)   begin errors++; $display("FAIL hold_state got %0d want 2", st_a); end
    cyc(1'b1, 32'd25, 32'd0, 1'b0);
    cyc(1'b1, 32'd30, 32'd1, 1'b0);
    checks++; if (fcyc_a !== 16'd6) begin errors++; $display("FAIL hold_fcyc got %0d want 6", fcyc_a); end
    checks++; if (fexp_a !== 32'h75) begin errors++; $display("FAIL hold_fexp got %h want 75", fexp_a); end
  endtask

  task automatic test_bypass();
    do_clear();
    for (int k = 0; k < 10; k++) begin
      byp_sel = (k >= 5);
      cyc(1'b1, 32'(5 * k), 32'd0, 1'b0);
    end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL byp_clean_err got %0d want 0", err_a); end
    byp_sel = 1'b1; byp_use_exp = 1'b1;
    cyc(1'b1, 32'd50, 32'd0, 1'b0);
`ifdef ACCUM_RESULT_MONITOR_BYPASS_CHECK_EN
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL byp_bad_err got %0d want 1", err_a); end
`else
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL byp_ignored_err got %0d want 0", err_a); end
`endif
    byp_sel = 1'b0; byp_use_exp = 1'b0;
  endtask

  task automatic test_wrap();
    do_clear();
    cyc(1'b1, 32'hFFFF_FFE9, 32'd0, 1'b0);
    cyc(1'b1, 32'h0000_0010, 32'd0, 1'b0);
    cyc(1'b1, 32'd0, 32'd0, 1'b0);
    checks++; if (err_a !== 1'b0)  begin errors++; $display("FAIL wrap_err got %0d want 0", err_a); end
    checks++; if (chk_a !== 16'd2) begin errors++; $display("FAIL wrap_chk got %0d want 2", chk_a); end
  endtask

  task automatic test_saturate();
    do_clear();
    cyc(1'b1, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b1, 32'd0, 32'd1, 1'b0);
    checks++; if (ecnt_c !== 4'hF)  begin errors++; $display("FAIL sat_ecnt got %0d want 15", ecnt_c); end
    checks++; if (chk_c !== 4'hF)   begin errors++; $display("FAIL sat_chk got %0d want 15", chk_c); end
    checks++; if (fcyc_c !== 4'd1)  begin errors++; $display("FAIL sat_fcyc got %0d want 1", fcyc_c); end
    checks++; if (fexp_c !== 32'd7) begin errors++; $display("FAIL sat_fexp got %h want 7", fexp_c); end
    checks++; if (fgot_c !== 32'd6) begin errors++; $display("FAIL sat_fgot got %h want 6", fgot_c); end
  endtask

  task automatic test_clear_reset();
    do_clear();
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'(5 * k), 32'd0, 1'b0);
    cyc(1'b1, 32'd20, 32'd1, 1'b1);
    checks++; if (err_a !== 1'b0)   begin errors++; $display("FAIL clr_err got %0d want 0", err_a); end
    checks++; if (ecnt_a !== 16'd0) begin errors++; $display("FAIL clr_ecnt got %0d want 0", ecnt_a); end
    checks++; if (chk_a !== 16'd0)  begin errors++; $display("FAIL clr_chk got %0d want 0", chk_a); end
    checks++; if ({fcyc_a, fexp_a, fgot_a} !== 64'd0) begin errors++; $display("FAIL clr_capture got %h/%h/%h want 0", fcyc_a, fexp_a, fgot_a); end
    checks++; if (st_a !== IDLE)    begin errors++; $display("FAIL clr_state got %0d want 0", st_a); end
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'(5 * k), (k == 3) ? 32'd1 : 32'd0, 1'b0);
    checks++; if (err_n !== 1'b1)   begin errors++; $display("FAIL pre_rst_err got %0d want 1", err_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (err_n !== 1'b0)   begin errors++; $display("FAIL rst_err got %0d want 0", err_n); end
    checks++; if ({ecnt_n, chk_n, fcyc_n} !== 48'd0) begin errors++; $display("FAIL rst_counts got %h/%h/%h want 0", ecnt_n, chk_n, fcyc_n); end
    checks++; if ({fexp_n, fgot_n} !== 64'd0) begin errors++; $display("FAIL rst_capture got %h/%h want 0", fexp_n, fgot_n); end
    checks++; if (st_n !== IDLE)    begin errors++; $display("FAIL rst_state got %0d want 0", st_n); end
    @(negedge clk);
    rst_n = 1'b1;
    acc = 32'd0;
  endtask

  initial begin
    acc = 32'd0; byp_sel = 1'b0; byp_use_exp = 1'b0;
    bus.enable = 1'b0; bus.clear = 1'b0; bus.accum_in = '0;
    bus.accum_bypass = 1'b0; bus.accum_out = '0; bus.accum_bypass_out = '0;
    test_reset();
    test_clean_run();
    test_stop_on_err();
    test_continue();
    test_enable_hold();
    test_bypass();
    test_wrap();
    test_saturate();
    test_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
